uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT, default 4096, clk cycles allowed from newd assertion to donetx rising.
REQ-003 clk  input  1  system clock, same clk that feeds the transmitter.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester level request; byte held stable while high.
REQ-006 req_data  input  8*NUM_REQ  byte i at bits [8i+7:8i].
REQ-007 gnt  output  NUM_REQ  one-hot, one-cycle pulse when byte i is latched.
REQ-008 done  output  NUM_REQ  one-cycle pulse when requester i's frame completes.
REQ-009 err  output  1  one-cycle pulse on timeout abort.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 newd  output  1  to transmitter newd.
REQ-012 tx_data  output  8  to transmitter tx_data.
REQ-013 donetx  input  1  from transmitter donetx.

Function
REQ-014 FSM states: IDLE, LOAD, WAIT_DONE, RELEASE.
REQ-015 IDLE: when any req is high, grant by round-robin starting at pointer ptr. Latch that byte into tx_data, pulse gnt[i] and go to LOAD, all in the same cycle.
REQ-016 After a grant, ptr = (i+1) mod NUM_REQ. Reset value of ptr = 0.
REQ-017 LOAD: assert newd, clear the timeout counter, go to WAIT_DONE on the next cycle.
REQ-018 WAIT_DONE: hold newd high. On a rising edge of donetx (donetx=1 and its one-clk registered copy=0): drop newd, pulse done[owner], go to RELEASE.
REQ-019 A donetx already high on entry to WAIT_DONE is not an edge and is ignored.
REQ-020 RELEASE: newd low; return to IDLE on the first cycle with donetx=0.
REQ-021 tx_data holds the latched byte from the grant until the next grant.
REQ-022 req is ignored outside IDLE; no new grant occurs while busy.
REQ-023 A requester whose req stays high after gnt is treated as a new request. It wins again only when its turn comes in round-robin order.
REQ-024 Simultaneous requests: exactly one gnt bit per grant; gnt is never asserted outside IDLE.
REQ-025 done, gnt and err are never asserted in the same cycle.

Reset
REQ-026 On rst low, asynchronously: state=IDLE, newd=0, tx_data=8'h00, gnt=0, done=0, err=0, busy=0, ptr=0, timeout counter=0, registered donetx=0.
REQ-027 Reset mid-frame abandons the owner with no done or err pulse. After release the block waits in IDLE; the transmitter finishing its frame produces no done.

Configuration
REQ-028 Macro UART_TX_ARBITER_TIMEOUT_EN, when defined, enables the timeout. In WAIT_DONE the counter increments every clk. When it reaches TIMEOUT-1 with no donetx edge: newd=0, pulse err, no done pulse, go to RELEASE.
REQ-029 When UART_TX_ARBITER_TIMEOUT_EN is undefined: the err port remains and is tied 0, no counter exists, and WAIT_DONE waits indefinitely.

Structure
REQ-030 Package uart_arb_pkg holds the state enum type and the constant for the default NUM_REQ.
REQ-031 Sub-module rr_arbiter (inputs req, ptr; output one-hot grant) is purely combinational and instantiated once.

Verification
REQ-032 Single request: req[2]=1, req_data byte2=8'hA5. Required: gnt[2] pulse, tx_data=8'hA5, newd high until donetx rise, done[2] pulse, serial line shows 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop).
REQ-033 All four requesting from reset with bytes 8'h11, 8'h22, 8'h33, 8'h44. Required: grants in order 0,1,2,3, four frames, four done pulses, busy low at end.
REQ-034 Fairness: req[0] held high continuously, req[3] rising mid-frame. Required: next grant goes to 3, then 0.
REQ-035 Stuck transmitter with the macro defined: donetx tied 0, TIMEOUT=64. Required: err pulses 64 cycles after entering WAIT_DONE, newd drops, block returns to IDLE, no done pulse.
REQ-036 Reset mid-WAIT_DONE (rst low for 3 clk). Required: newd=0 immediately, outputs at reset values, no done pulse for the abandoned frame, next request is served normally.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module  : uart_arb_pkg
// Brief   : Shared state type and default sizing for the UART TX arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

    localparam int c_num_req_default = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RELEASE   = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin picker; first active request at or after ptr wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = c_num_req_default,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    localparam logic [PTR_W:0] c_n = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // ptr and the offset are both below NUM_REQ, so one conditional subtract wraps
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_sum >= c_n) begin
                w_sum = w_sum - c_n;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Shares one UART transmitter among NUM_REQ requesters, round-robin.
//           Define UART_TX_ARBITER_TIMEOUT_EN to abort frames with no donetx.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = c_num_req_default,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic                 busy,
    output logic                 newd,
    output logic [7:0]           tx_data,
    input  logic                 donetx
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [7:0]         w_gnt_byte;
    logic [NUM_REQ-1:0] w_grant;
    logic               r_donetx_q;
    logic               w_donetx_rise;
    logic               w_timeout;
    logic               w_take;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    always_comb begin
        w_gnt_idx  = '0;
        w_gnt_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_gnt_idx  = PTR_W'(k);
                w_gnt_byte = req_data[8*k +: 8];
            end
        end
    end

    assign w_ptr_nxt     = (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + PTR_W'(1);
    assign w_donetx_rise = donetx & ~r_donetx_q;
    assign w_take        = (r_state == ST_IDLE) && rst && (|w_grant);
    assign busy          = (r_state != ST_IDLE);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_LOAD) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT_DONE) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == ST_WAIT_DONE) && (r_cnt == c_cnt_last);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        done        = '0;
        err         = 1'b0;
        newd        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    gnt         = w_grant;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                newd        = 1'b1;
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // a genuine completion edge takes priority over an expiring timeout
                if (w_donetx_rise) begin
                    done[r_owner] = 1'b1;
                    w_state_nxt   = ST_RELEASE;
                end else if (w_timeout) begin
                    err         = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    newd = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!donetx) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            tx_data    <= 8'h00;
            r_donetx_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_donetx_q <= donetx;
            if (w_take) begin
                tx_data <= w_gnt_byte;
                r_owner <= w_gnt_idx;
                r_ptr   <= w_ptr_nxt;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Directed bench for uart_tx_arbiter with a cycle-level transmitter model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;
    localparam int BIT_CYC = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic        newd;
    logic [7:0]  tx_data;
    logic        donetx;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .newd     (newd),
        .tx_data  (tx_data),
        .donetx   (donetx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gnt, done and err must never coincide; gnt is one-hot and only while idle
    always @(negedge clk) begin
        check("excl", 32'(((gnt != 0) ? 1 : 0) + ((done != 0) ? 1 : 0) + (err ? 1 : 0)) <= 1, 1);
        check("gnt_onehot_idle", ($countones(gnt) <= 1) && !(busy && (gnt != 0)), 1);
    end

    // Transmitter model: entered in the LOAD cycle, samples the line once per bit.
    task automatic serve(input int owner, input logic [9:0] exp_line,
                         input logic [3:0] raise, input string tag);
        logic [9:0] line;
        line = '0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BIT_CYC; c++) begin
                tick();
                if (b == 4 && c == 0) req = req | raise;
                #4;
                if (c == 0) begin
                    if (b == 0)      line[b] = 1'b0;
                    else if (b == 9) line[b] = 1'b1;
                    else             line[b] = tx_data[b-1];
                    check({tag, "_newd_hold"}, newd, 1);
                end
            end
        end
        tick();
        donetx = 1'b1;
        #4;
        check({tag, "_done"}, done, 32'(1) << owner);
        check({tag, "_newd_drop"}, newd, 0);
        tick();
        donetx = 1'b0;
        #4;
        check({tag, "_release_busy"}, busy, 1);
        check({tag, "_release_done"}, done, 0);
        check({tag, "_line"}, line, exp_line);
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  done_seen;
        logic newd_at;

        rst = 1'b0; req = '0; req_data = '0; donetx = 1'b0;
        repeat (3) tick();
        #4;
        check("rst_busy", busy, 0);
        check("rst_newd", newd, 0);
        check("rst_txdata", tx_data, 8'h00);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        tick(); rst = 1'b1;

        // single request, byte A5 on requester 2
        tick(); req = 4'b0100; req_data = 32'h00A5_0000; #4;
        check("t1_gnt", gnt, 4'b0100);
        check("t1_idle", busy, 0);
        tick(); req = '0; #4;
        check("t1_load_newd", newd, 1);
        check("t1_txdata", tx_data, 8'hA5);
        check("t1_load_busy", busy, 1);
        serve(2, 10'b1101001010, 4'b0000, "t1");

        // all four from reset: grants 0,1,2,3
        tick(); rst = 1'b0;
        tick(); rst = 1'b1;
        tick(); req = 4'b1111; req_data = 32'h4433_2211;
        for (int k = 0; k < 4; k++) begin
            #4;
            check("t2_gnt", gnt, 32'(1) << k);
            tick(); req[k] = 1'b0; #4;
            check("t2_txdata", tx_data, 8'h11 * (k + 1));
            serve(k, {1'b1, 8'(8'h11 * (k + 1)), 1'b0}, 4'b0000, "t2");
            tick();
        end
        #4;
        check("t2_end_busy", busy, 0);
        check("t2_end_gnt", gnt, 0);

        // fairness: req0 held, req3 rises mid-frame -> 3 then 0
        tick(); req = 4'b0001; req_data = 32'hC300_003C; #4;
        check("t3_gnt0", gnt, 4'b0001);
        tick(); #4;
        serve(0, {1'b1, 8'h3C, 1'b0}, 4'b1000, "t3a");
        tick(); #4;
        check("t3_gnt3", gnt, 4'b1000);
        tick(); req[3] = 1'b0; #4;
        check("t3_txdata3", tx_data, 8'hC3);
        serve(3, {1'b1, 8'hC3, 1'b0}, 4'b0000, "t3b");
        tick(); #4;
        check("t3_gnt0_again", gnt, 4'b0001);
        tick(); req = '0; #4;
        check("t3_txdata0", tx_data, 8'h3C);
        serve(0, {1'b1, 8'h3C, 1'b0}, 4'b0000, "t3c");
        tick(); #4;
        check("t3_end_busy", busy, 0);

        // donetx already high on entry to WAIT_DONE is ignored
        tick(); req = 4'b0010; req_data = 32'h0000_5A00; #4;
        check("t5_gnt", gnt, 4'b0010);
        tick(); req = '0; donetx = 1'b1; #4;
        tick(); #4;
        check("t5_no_done_a", done, 0);
        check("t5_newd_a", newd, 1);
        tick(); #4;
        check("t5_no_done_b", done, 0);
        tick(); donetx = 1'b0; #4;
        check("t5_newd_b", newd, 1);
        serve(1, {1'b1, 8'h5A, 1'b0}, 4'b0000, "t5");
        tick(); #4;
        check("t5_end_busy", busy, 0);

        // reset in WAIT_DONE
        tick(); req = 4'b0100; req_data = 32'h0096_0000; #4;
        check("t4_gnt", gnt, 4'b0100);
        tick(); req = '0; #4;
        repeat (3) tick();
        #4;
        check("t4_wait_newd", newd, 1);
        tick(); rst = 1'b0; #1;
        check("t4_rst_newd", newd, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_txdata", tx_data, 8'h00);
        check("t4_rst_gnt", gnt, 0);
        check("t4_rst_err", err, 0);
        tick(); donetx = 1'b1; #4;
        check("t4_rst_done", done, 0);
        tick(); donetx = 1'b0; #4;
        tick(); rst = 1'b1; #4;
        check("t4_post_busy", busy, 0);
        tick(); donetx = 1'b1; #4;
        check("t4_stale_done", done, 0);
        check("t4_stale_busy", busy, 0);
        tick(); donetx = 1'b0;
        // ptr back at 0 after reset: 1100 must grant 2, not 3
        tick(); req = 4'b1100; req_data = 32'h7796_0000; #4;
        check("t4_next_gnt", gnt, 4'b0100);
        tick(); req = '0; #4;
        check("t4_next_txdata", tx_data, 8'h96);
        serve(2, {1'b1, 8'h96, 1'b0}, 4'b0000, "t4");
        tick(); #4;
        check("t4_end_busy", busy, 0);

        // stuck transmitter
        tick(); req = 4'b0001; req_data = 32'h0000_00E7; #4;
        check("t6_gnt", gnt, 4'b0001);
        tick(); req = '0; #4;
        n = 0; seen = 1'b0; done_seen = 1'b0; newd_at = 1'b1;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        while (!seen && n < 200) begin
            tick(); #4;
            n++;
            if (|done) done_seen = 1'b1;
            if (err) begin
                seen    = 1'b1;
                newd_at = newd;
            end
        end
        check("t6_err_seen", seen, 1);
        check("t6_err_cycle", n, 64);
        check("t6_err_newd", newd_at, 0);
        check("t6_no_done", done_seen, 0);
        tick(); #4;
        check("t6_release_busy", busy, 1);
        tick(); #4;
        check("t6_idle_busy", busy, 0);
        check("t6_idle_err", err, 0);
`else
        while (n < 100) begin
            tick(); #4;
            n++;
            if (err) seen = 1'b1;
            if (|done) done_seen = 1'b1;
        end
        check("t6_no_err", seen, 0);
        check("t6_no_done", done_seen, 0);
        check("t6_still_newd", newd, 1);
        tick(); donetx = 1'b1; #4;
        check("t6_late_done", done, 4'b0001);
        tick(); donetx = 1'b0; #4;
        tick(); #4;
        check("t6_idle_busy", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
